mem_stage_wb: RTL and testbench
===============================

# mem_stage_wb

Memory-stage consumer of the EX/MEM pipeline register outputs for the pipelined MIPS core. The block accepts the M-stage control and data, runs the data-memory request/ready handshake for loads and stores, and stalls upstream while memory is busy. It then registers the results into the MEM/WB stage: W-stage control, ALU result, read data, the selected writeback result and the destination register.

## Interface
- MAX_WAIT, 16, maximum request cycles before a memory access is aborted; must be ≥1.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- RegWriteM  in  1  register write enable from the EX/MEM register.
- MemtoRegM  in  1  load indicator; the result comes from memory.
- MemWriteM  in  1  store indicator.
- ALUOutM  in  32  ALU result; this is the byte address for loads and stores.
- WriteDataM  in  32  store data.
- WriteRegM  in  5  destination register.
- mem_req  out  1  data-memory request (combinational).
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr  out  32  equals ALUOutM.
- mem_wdata  out  32  equals WriteDataM.
- mem_ready  in  1  memory completes the request in the current cycle.
- mem_rdata  in  32  load data, valid when mem_ready is 1.
- StallM  out  1  holds the EX/MEM register and all earlier stages.
- RegWriteW  out  1  registered write enable.
- MemtoRegW  out  1  registered load indicator.
- ALUOutW  out  32  registered ALU result.
- ReadDataW  out  32  registered load data.
- ResultW  out  32  registered writeback value: ReadDataW if MemtoRegW, else ALUOutW.
- WriteRegW  out  5  registered destination register.
- mem_timeout  out  1  sticky flag: an access was aborted because MAX_WAIT was reached.
- mem_misalign  out  1  sticky flag: an access was issued with ALUOutM[1:0] not equal to 0.

## Operation
- An access is any cycle where MemtoRegM or MemWriteM is 1. If both are 1, the access is treated as a store.
- A misaligned access issues no request and no stall. The W stage loads a bubble (RegWriteW=0, MemtoRegW=0) and mem_misalign is set.
- For an aligned access: mem_req=1, mem_we=MemWriteM, mem_addr=ALUOutM, mem_wdata=WriteDataM.
- For a non-access cycle: mem_req=0 and StallM=0. The M-stage values load into the W stage on the next edge.
- State machine IDLE/WAIT, with a wait counter cnt of width clog2(MAX_WAIT+1):
  - IDLE, aligned access with mem_ready=1: the access completes this cycle. StallM=0, the W stage captures the M-stage values and ReadDataW←mem_rdata (loads only). Stay in IDLE.
  - IDLE, aligned access with mem_ready=0 and MAX_WAIT>1: StallM=1, go to WAIT with cnt=1.
  - WAIT, mem_ready=1: the access completes as in IDLE. Go to IDLE with cnt=0.
  - WAIT, mem_ready=0 and cnt+1<MAX_WAIT: StallM=1, cnt increments.
  - Abort: mem_ready=0 on the MAX_WAIT-th request cycle. StallM=0, W loads a bubble, mem_timeout is set, go to IDLE with cnt=0. A store is dropped; a load does not write the register file.
  - MAX_WAIT=1 with mem_ready=0 in IDLE aborts immediately, with no stall cycle.
- While StallM=1 the W stage loads a bubble every cycle (RegWriteW=0, MemtoRegW=0; the data fields hold), so the register file is never written twice.
- Upstream holds the M inputs stable while StallM=1. The block does not re-latch them.
- ReadDataW holds its value on non-load cycles.
- Both sticky flags clear only on rst.

## Timing
- Reset: while rst=1, mem_req=0 and StallM=0. On the edge with rst=1, all W outputs, mem_timeout, mem_misalign, the state (IDLE) and cnt are cleared to 0.
- Reset mid-WAIT: the pending access is abandoned and no W update occurs. The first cycle after rst falls is IDLE.
- Latency, non-memory op: M→W in 1 cycle.
- Latency, memory access: W is valid 1 cycle after the mem_ready cycle. StallM is high for exactly (number of request cycles − 1) cycles.
- The request is combinational: mem_req rises in the same cycle the access appears on the M inputs.
- Abort and completion cannot coincide: mem_ready=1 on the final allowed cycle counts as completion.
- Consecutive accesses: a new access may begin in the cycle after a completion. There are no idle cycles between back-to-back zero-wait accesses.

## Test plan
- Reset: drive rst=1 for 2 cycles with random inputs → all W outputs and flags are 0; mem_req=0 and StallM=0 throughout.
- ALU op: RegWriteM=1, ALUOutM=0x00001234, WriteRegM=5 → next cycle RegWriteW=1, ResultW=0x00001234, WriteRegW=5; mem_req stays 0.
- Zero-wait load: MemtoRegM=1, RegWriteM=1, ALUOutM=0x100, mem_ready=1, mem_rdata=0xDEADBEEF → StallM never asserted; next cycle ReadDataW=ResultW=0xDEADBEEF, MemtoRegW=1.
- Store with 3 wait cycles: MemWriteM=1, ALUOutM=0x200, WriteDataM=0xCAFEF00D, mem_ready asserted on the 4th request cycle → StallM=1 for 3 cycles, mem_we=1 and mem_wdata=0xCAFEF00D throughout, RegWriteW=0 on every cycle.
- Timeout with MAX_WAIT=4, load, mem_ready held 0 → StallM=1 for 3 cycles and 0 on the 4th; then mem_timeout=1 and RegWriteW=0. mem_timeout stays 1 after a later successful access.
- Misaligned load to ALUOutM=0x102 → mem_req=0, StallM=0; next cycle mem_misalign=1, RegWriteW=0. Also apply rst=1 during the 2nd WAIT cycle of a load → IDLE with no W write afterwards.

Source files
------------

// File: rtl/mem_stage_wb.sv
// Memory stage of the pipelined MIPS core: handles the data-memory request/ready
// handshake, stalls upstream while memory is busy, and registers results into MEM/WB.
module mem_stage_wb #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ALUOutW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ResultW,
    output logic [4:0]  WriteRegW,
    output logic        mem_timeout,
    output logic        mem_misalign
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WAIT - 1);
    localparam bit CAN_WAIT = (MAX_WAIT > 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    logic access, is_load, misalign, aligned_access;
    logic stall, w_load, timeout_set;

    // Store wins when both load and store are flagged.
    assign access         = MemtoRegM | MemWriteM;
    assign is_load        = MemtoRegM & ~MemWriteM;
    assign misalign       = access & (ALUOutM[1:0] != 2'b00);
    assign aligned_access = access & ~misalign;

    assign mem_req   = aligned_access & ~rst;
    assign mem_we    = mem_req & MemWriteM;
    assign mem_addr  = ALUOutM;
    assign mem_wdata = WriteDataM;
    assign StallM    = stall & ~rst;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        stall       = 1'b0;
        w_load      = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (!access || (aligned_access && mem_ready)) begin
                    w_load = 1'b1;
                end else if (aligned_access) begin
                    if (CAN_WAIT) begin
                        stall      = 1'b1;
                        state_next = WAIT;
                        cnt_next   = CW'(1);
                    end else begin
                        timeout_set = 1'b1;
                    end
                end
            end
            WAIT: begin
                state_next = IDLE;
                cnt_next   = '0;
                if (aligned_access && mem_ready) begin
                    w_load = 1'b1;
                end else if (aligned_access && cnt < LAST_CNT) begin
                    stall      = 1'b1;
                    state_next = WAIT;
                    cnt_next   = cnt + CW'(1);
                end else if (aligned_access) begin
                    timeout_set = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers
    // sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            RegWriteW    <= 1'b0;
            MemtoRegW    <= 1'b0;
            ALUOutW      <= '0;
            ReadDataW    <= '0;
            ResultW      <= '0;
            WriteRegW    <= '0;
            mem_timeout  <= 1'b0;
            mem_misalign <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (w_load) begin
                RegWriteW <= RegWriteM;
                MemtoRegW <= is_load;
                ALUOutW   <= ALUOutM;
                WriteRegW <= WriteRegM;
                ResultW   <= is_load ? mem_rdata : ALUOutM;
                if (is_load) ReadDataW <= mem_rdata;
            end else begin
                // Bubble: no register-file write, data fields hold.
                RegWriteW <= 1'b0;
                MemtoRegW <= 1'b0;
                ResultW   <= ALUOutW;
            end
            if (timeout_set) mem_timeout  <= 1'b1;
            if (misalign)    mem_misalign <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage_wb.sv
// Self-checking bench for mem_stage_wb: directed plan steps plus random operations
// checked against a transaction-level model of the W stage and flags.
module tb_mem_stage_wb;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        StallM;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] ALUOutW, ReadDataW, ResultW;
    logic [4:0]  WriteRegW;
    logic        mem_timeout, mem_misalign;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the W stage and sticky flags
    logic        m_rw, m_mtr, m_to, m_mis;
    logic [31:0] m_alu, m_rd, m_res;
    logic [4:0]  m_reg;

    mem_stage_wb #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .StallM(StallM),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ALUOutW(ALUOutW),
        .ReadDataW(ReadDataW), .ResultW(ResultW), .WriteRegW(WriteRegW),
        .mem_timeout(mem_timeout), .mem_misalign(mem_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag);
        check({tag, ".RegWriteW"},    32'(RegWriteW),    32'(m_rw));
        check({tag, ".MemtoRegW"},    32'(MemtoRegW),    32'(m_mtr));
        check({tag, ".ALUOutW"},      ALUOutW,           m_alu);
        check({tag, ".ReadDataW"},    ReadDataW,         m_rd);
        check({tag, ".ResultW"},      ResultW,           m_res);
        check({tag, ".WriteRegW"},    32'(WriteRegW),    32'(m_reg));
        check({tag, ".mem_timeout"},  32'(mem_timeout),  32'(m_to));
        check({tag, ".mem_misalign"}, 32'(mem_misalign), 32'(m_mis));
    endtask

    task automatic model_reset();
        m_rw = 0; m_mtr = 0; m_to = 0; m_mis = 0;
        m_alu = '0; m_rd = '0; m_res = '0; m_reg = '0;
    endtask

    // One M-stage operation; lat = number of not-ready request cycles before ready.
    task automatic do_op(input string tag, input bit ld, input bit st, input bit rw,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] wreg, input int lat, input logic [31:0] rdata);
        bit access, aligned, timeout;
        int reqs;
        access  = ld | st;
        aligned = access && (addr[1:0] == 2'b00);
        timeout = aligned && (lat + 1 > MAX_WAIT);
        reqs    = !aligned ? 1 : (timeout ? MAX_WAIT : lat + 1);
        RegWriteM = rw; MemtoRegM = ld; MemWriteM = st;
        ALUOutM = addr; WriteDataM = wd; WriteRegM = wreg;
        for (int i = 0; i < reqs; i++) begin
            mem_ready = aligned && (i == lat);
            mem_rdata = (i == lat) ? rdata : $urandom;
            @(negedge clk);
            check({tag, ".mem_req"}, 32'(mem_req), 32'(aligned));
            check({tag, ".mem_we"},  32'(mem_we),  32'(aligned && st));
            check({tag, ".StallM"},  32'(StallM),  32'(i < reqs - 1));
            if (aligned) begin
                check({tag, ".mem_addr"},  mem_addr,  addr);
                check({tag, ".mem_wdata"}, mem_wdata, wd);
            end
            @(posedge clk); #1;
            if (i < reqs - 1) begin
                check({tag, ".stall_bubble_rw"},  32'(RegWriteW), 32'(0));
                check({tag, ".stall_bubble_mtr"}, 32'(MemtoRegW), 32'(0));
            end
        end
        mem_ready = 0;
        if (!access || (aligned && !timeout)) begin
            m_rw  = rw;
            m_mtr = ld && !st;
            m_alu = addr;
            m_reg = wreg;
            if (ld && !st) m_rd = rdata;
            m_res = m_mtr ? m_rd : m_alu;
        end else begin
            m_rw  = 0;
            m_mtr = 0;
            m_res = m_alu;
        end
        if (access && !aligned) m_mis = 1;
        if (timeout) m_to = 1;
        check_w(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs
        rst = 1; mem_ready = 0; mem_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            RegWriteM = 1'($urandom); MemtoRegM = 1'($urandom); MemWriteM = 1'($urandom);
            ALUOutM = $urandom; WriteDataM = $urandom; WriteRegM = 5'($urandom);
            mem_ready = 1'($urandom); mem_rdata = $urandom;
            @(negedge clk);
            check("reset.mem_req", 32'(mem_req), 32'(0));
            check("reset.StallM",  32'(StallM),  32'(0));
            @(posedge clk); #1;
        end
        rst = 0;
        model_reset();
        check_w("reset");

        // Directed plan steps
        do_op("alu",        0, 0, 1, 32'h0000_1234, 32'h0,         5'd5, 0, 32'h0);
        do_op("load0",      1, 0, 1, 32'h0000_0100, 32'h0,         5'd7, 0, 32'hDEAD_BEEF);
        do_op("store3",     0, 1, 0, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 3, 32'h0);
        do_op("timeout",    1, 0, 1, 32'h0000_0300, 32'h0,         5'd9, 99, 32'h0);
        do_op("after_to",   1, 0, 1, 32'h0000_0304, 32'h0,         5'd10, 1, 32'h1357_9BDF);
        do_op("misalign",   1, 0, 1, 32'h0000_0102, 32'h0,         5'd11, 0, 32'h0);
        do_op("both_store", 1, 1, 0, 32'h0000_0400, 32'h2468_ACE0, 5'd3, 0, 32'h5555_AAAA);

        // Reset during the 2nd WAIT cycle of a load
        RegWriteM = 1; MemtoRegM = 1; MemWriteM = 0;
        ALUOutM = 32'h0000_0500; WriteDataM = '0; WriteRegM = 5'd12;
        mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_wait.StallM", 32'(StallM), 32'(1));
            @(posedge clk); #1;
        end
        rst = 1;
        mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check("rst_wait.mem_req_in_rst", 32'(mem_req), 32'(0));
        check("rst_wait.StallM_in_rst",  32'(StallM),  32'(0));
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        check_w("rst_wait");
        do_op("post_rst_nop",  0, 0, 0, 32'h0000_0000, 32'h0, 5'd0, 0, 32'h0);
        do_op("post_rst_load", 1, 0, 1, 32'h0000_0600, 32'h0, 5'd13, 0, 32'h0BAD_CAFE);

        // Randomized operations
        for (int n = 0; n < 300; n++) begin
            bit ld, st, rw;
            logic [31:0] addr;
            int sel;
            sel  = $urandom_range(0, 3);
            ld   = (sel == 1) || (sel == 3 && $urandom_range(0, 3) == 0);
            st   = (sel == 2) || (sel == 3);
            rw   = 1'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
            do_op("rand", ld, st, rw, addr, $urandom, 5'($urandom),
                  $urandom_range(0, MAX_WAIT + 1), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
